// File: rtl/dragonfang_pkg.sv
// rtl/dragonfang_pkg.sv - shared types and beat/mask helpers for the vector sqrt sequencer
package dragonfang_pkg;

  typedef enum logic [1:0] {
    BIT_MODE_DISABLED  = 2'd0,
    ENABLED_32BIT_MODE = 2'd1,
    ENABLED_64BIT_MODE = 2'd2,
    BIT_MODE_RESERVED  = 2'd3
  } bit_mode_t;

  typedef struct packed {
    bit_mode_t bit_mode;
    logic      reciprocal_mode;
  } execution_vector_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

  // Number of 64-bit beats an operation touches; unsupported modes touch none.
  function automatic int beat_count(input bit_mode_t bit_mode, input int vl, input int beats);
    int n;
    case (bit_mode)
      ENABLED_64BIT_MODE: n = vl;
      ENABLED_32BIT_MODE: n = (vl + 1) / 2;
      default:            n = 0;
    endcase
    return (n > beats) ? beats : n;
  endfunction

  // An odd 32-bit element count leaves the upper lane of the last beat unwritten.
  // Counts beyond 2*beats clamp to an even value, so they always use the full mask.
  function automatic logic [7:0] last_beat_mask(input bit_mode_t bit_mode, input int vl, input int beats);
    return (bit_mode == ENABLED_32BIT_MODE && vl < 2 * beats && vl[0]) ? 8'h0F : 8'hFF;
  endfunction

endpackage

// File: rtl/vector_floating_point_square_root_sequencer_if.sv
// rtl/vector_floating_point_square_root_sequencer_if.sv - vector register file read/write port bundle
// master: sequencer side (drives read request and write beat, receives vs2 data)
// slave:  register file side
interface vector_floating_point_square_root_sequencer_if #(
  parameter int VLEN = 512
);
  localparam int BEAT_W = $clog2(VLEN / 64);

  logic              rf_read_enable;
  logic [BEAT_W-1:0] rf_read_beat;
  logic [63:0]       rf_read_data;
  logic              rf_write_enable;
  logic [BEAT_W-1:0] rf_write_beat;
  logic [63:0]       rf_write_data;
  logic [7:0]        rf_write_mask;

  modport master (
    output rf_read_enable, rf_read_beat, rf_write_enable, rf_write_beat, rf_write_data, rf_write_mask,
    input  rf_read_data
  );

  modport slave (
    input  rf_read_enable, rf_read_beat, rf_write_enable, rf_write_beat, rf_write_data, rf_write_mask,
    output rf_read_data
  );
endinterface

// File: rtl/vector_floating_point_square_root_unit.sv
// rtl/vector_floating_point_square_root_unit.sv - combinational 64-bit-beat sqrt / reciprocal sqrt datapath
// Ports: execution_vector (lane width, reciprocal select), vs2 (source beat), vd (result beat).
// Results truncate toward zero; subnormal inputs are treated as zero.
module vector_floating_point_square_root_unit
  import dragonfang_pkg::*;
(
  input  execution_vector_t execution_vector,
  input  logic [63:0]       vs2,
  output logic [63:0]       vd
);

  function automatic logic [63:0] f64_sqrt(input logic [63:0] x, input logic recip);
    logic [10:0]  e;
    logic [51:0]  f;
    logic [53:0]  m;
    logic [105:0] rad;
    logic [105:0] sq;
    logic [52:0]  r;
    logic [52:0]  t;
    logic [53:0]  q;
    int           ue;
    e = x[62:52];
    f = x[51:0];
    if (e == 11'h7FF && f != 52'd0) return 64'h7FF8_0000_0000_0000;
    if (e == 11'd0) return recip ? {x[63], 11'h7FF, 52'd0} : {x[63], 63'd0};
    if (x[63]) return 64'h7FF8_0000_0000_0000;
    if (e == 11'h7FF) return recip ? 64'd0 : {1'b0, 11'h7FF, 52'd0};
    // Fold an odd exponent into the mantissa so the exponent halves exactly.
    ue = int'(e) - 1023;
    m  = {2'b01, f};
    if (ue[0]) begin
      m  = m << 1;
      ue = ue - 1;
    end
    // Bitwise integer square root of m * 2^52 gives a 53-bit mantissa with its leading one at bit 52.
    rad = {m, 52'd0};
    r   = 53'd0;
    for (int b = 52; b >= 0; b--) begin
      t  = r | (53'd1 << b);
      sq = {53'd0, t} * {53'd0, t};
      if (sq <= rad) r = t;
    end
    if (!recip) return {1'b0, 11'(ue / 2 + 1023), r[51:0]};
    // 2^105 / r lies in (2^52, 2^53]; the top value only occurs for an exact power of four.
    q = 54'({1'b1, 105'd0} / {53'd0, r});
    if (q[53]) return {1'b0, 11'(1023 - ue / 2), 52'd0};
    return {1'b0, 11'(1022 - ue / 2), q[51:0]};
  endfunction

  // Single precision goes through the double path; truncating twice equals truncating once.
  function automatic logic [31:0] f32_sqrt(input logic [31:0] x, input logic recip);
    logic [63:0] w;
    logic [63:0] y;
    logic        unused_lsbs;
    if (x[30:23] == 8'hFF)      w = {x[31], 11'h7FF, x[22:0], 29'd0};
    else if (x[30:23] == 8'd0)  w = {x[31], 63'd0};
    else                        w = {x[31], 11'(int'(x[30:23]) + 896), x[22:0], 29'd0};
    y = f64_sqrt(w, recip);
    unused_lsbs = ^y[28:0];
    if (y[62:52] == 11'h7FF) return (y[51:0] != 52'd0) ? 32'h7FC0_0000 : {y[63], 8'hFF, 23'd0};
    if (y[62:52] == 11'd0) return {y[63], 31'd0};
    return {y[63], 8'(int'(y[62:52]) - 896), y[51:29]};
  endfunction

  always_comb begin
    vd = 64'd0;
    case (execution_vector.bit_mode)
      ENABLED_64BIT_MODE: vd = f64_sqrt(vs2, execution_vector.reciprocal_mode);
      ENABLED_32BIT_MODE: vd = {f32_sqrt(vs2[63:32], execution_vector.reciprocal_mode),
                                f32_sqrt(vs2[31:0],  execution_vector.reciprocal_mode)};
      default:            vd = 64'd0;
    endcase
  end

endmodule

// File: rtl/vector_floating_point_square_root_sequencer.sv
// rtl/vector_floating_point_square_root_sequencer.sv - streams a vector sqrt/rsqrt through the datapath one beat per cycle
// Ports: clk, rst_n (async active-low), start/abort control, execution_vector and vl captured at start,
//        rf (register file read/write port, master side), busy, done (one-cycle completion pulse).
// Pipeline: read request (cycle 1+k) -> vs2 valid and computed (2+k) -> registered write (3+k).
module vector_floating_point_square_root_sequencer
  import dragonfang_pkg::*;
#(
  parameter  int VLEN   = 512,
  localparam int BEATS  = VLEN / 64,
  localparam int BEAT_W = $clog2(BEATS),
  localparam int VL_W   = $clog2(VLEN / 32) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  execution_vector_t   execution_vector,
  input  logic [VL_W-1:0]     vl,
  vector_floating_point_square_root_sequencer_if.master rf,
  output logic                busy,
  output logic                done
);

  seq_state_t        state_q, state_d;
  execution_vector_t ev_q, ev_d;
  logic [VL_W-1:0]   vl_q, vl_d;
  logic              rd_en_q, rd_en_d;
  logic [BEAT_W-1:0] rd_beat_q, rd_beat_d;
  logic              rv_q, rv_d;            // rf_read_data carries a requested beat this cycle
  logic [BEAT_W-1:0] rv_beat_q, rv_beat_d;
  logic              wr_en_q, wr_en_d;
  logic [BEAT_W-1:0] wr_beat_q, wr_beat_d;
  logic [63:0]       wr_data_q, wr_data_d;
  logic [7:0]        wr_mask_q, wr_mask_d;
  logic              done_q, done_d;
  logic [63:0]       vd;
  int                n_in, n_cur;
  logic [7:0]        last_mask;

  vector_floating_point_square_root_unit u_sqrt (
    .execution_vector (ev_q),
    .vs2              (rf.rf_read_data),
    .vd               (vd)
  );

  assign n_in      = beat_count(execution_vector.bit_mode, int'(vl), BEATS);
  assign n_cur     = beat_count(ev_q.bit_mode, int'(vl_q), BEATS);
  assign last_mask = last_beat_mask(ev_q.bit_mode, int'(vl_q), BEATS);

  always_comb begin
    state_d   = state_q;
    ev_d      = ev_q;
    vl_d      = vl_q;
    rd_en_d   = 1'b0;
    rd_beat_d = rd_beat_q;
    rv_d      = rd_en_q;
    rv_beat_d = rd_en_q ? rd_beat_q : rv_beat_q;
    wr_en_d   = rv_q;
    wr_beat_d = wr_beat_q;
    wr_data_d = wr_data_q;
    wr_mask_d = wr_mask_q;
    done_d    = 1'b0;

    if (rv_q) begin
      wr_beat_d = rv_beat_q;
      wr_data_d = vd;
      wr_mask_d = (int'(rv_beat_q) == n_cur - 1) ? last_mask : 8'hFF;
    end

    if (abort) begin
      state_d = IDLE;
      rv_d    = 1'b0;
      wr_en_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            ev_d = execution_vector;
            vl_d = vl;
            if (n_in == 0) begin
              done_d = 1'b1;
            end else begin
              state_d   = RUN;
              rd_en_d   = 1'b1;
              rd_beat_d = '0;
            end
          end
        end
        RUN: begin
          if (int'(rd_beat_q) == n_cur - 1) begin
            state_d = DRAIN;
          end else begin
            rd_en_d   = 1'b1;
            rd_beat_d = rd_beat_q + 1'b1;
          end
        end
        DRAIN: begin
          if (wr_en_q && int'(wr_beat_q) == n_cur - 1) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ev_q      <= '0;
      vl_q      <= '0;
      rd_en_q   <= 1'b0;
      rd_beat_q <= '0;
      rv_q      <= 1'b0;
      rv_beat_q <= '0;
      wr_en_q   <= 1'b0;
      wr_beat_q <= '0;
      wr_data_q <= 64'd0;
      wr_mask_q <= 8'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ev_q      <= ev_d;
      vl_q      <= vl_d;
      rd_en_q   <= rd_en_d;
      rd_beat_q <= rd_beat_d;
      rv_q      <= rv_d;
      rv_beat_q <= rv_beat_d;
      wr_en_q   <= wr_en_d;
      wr_beat_q <= wr_beat_d;
      wr_data_q <= wr_data_d;
      wr_mask_q <= wr_mask_d;
      done_q    <= done_d;
    end
  end

  assign rf.rf_read_enable  = rd_en_q;
  assign rf.rf_read_beat    = rd_beat_q;
  assign rf.rf_write_enable = wr_en_q;
  assign rf.rf_write_beat   = wr_beat_q;
  assign rf.rf_write_data   = wr_data_q;
  assign rf.rf_write_mask   = wr_mask_q;
  assign busy               = (state_q != IDLE);
  assign done               = done_q;

endmodule

// File: tb/tb_vector_floating_point_square_root_sequencer.sv
// tb/tb_vector_floating_point_square_root_sequencer.sv - directed table-driven bench for the vector sqrt sequencer
module tb_vector_floating_point_square_root_sequencer;
  import dragonfang_pkg::*;

  localparam int VLEN = 512;
  localparam logic [63:0] IDLE_DATA = 64'h0123_4567_89AB_CDEF;

  typedef struct {
    bit_mode_t   mode;
    logic        recip;
    int          vl;
    logic [63:0] src;
    int          n;
    logic [63:0] exp_data;
    logic [7:0]  last_mask;
  } vec_t;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              abort;
  execution_vector_t execution_vector;
  logic [4:0]        vl;
  logic              busy;
  logic              done;
  logic [63:0]       cur_src;
  int                total;
  int                bad;
  vec_t              vecs [13];

  vector_floating_point_square_root_sequencer_if #(.VLEN(VLEN)) rf ();

  vector_floating_point_square_root_sequencer #(.VLEN(VLEN)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .abort            (abort),
    .execution_vector (execution_vector),
    .vl               (vl),
    .rf               (rf.master),
    .busy             (busy),
    .done             (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: data for a request seen in cycle c is presented throughout cycle c+1.
  initial begin
    logic fire;
    forever begin
      @(negedge clk);
      fire = rf.rf_read_enable;
      @(posedge clk);
      #1;
      rf.rf_read_data = fire ? cur_src : IDLE_DATA;
    end
  end

  task automatic chk(input string name, input int cyc, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  task automatic launch(input vec_t v);
    execution_vector.bit_mode        = v.mode;
    execution_vector.reciprocal_mode = v.recip;
    vl      = 5'(v.vl);
    cur_src = v.src;
    start   = 1'b1;
  endtask

  // cut >= 0: from cycle cut+1 on nothing may happen; kind 1 aborts / kind 2 resets at the end of cycle cut.
  // restart_c: a start pulse in that cycle that must be ignored. chain: launch nv in the done cycle.
  task automatic check_run(input vec_t v, input int cut, input int kind, input int restart_c,
                           input bit chain, input vec_t nv);
    bit   busy_e, rd_e, wr_e, done_e;
    logic [7:0] mask_e;
    for (int c = 1; c <= v.n + 4; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      rst_n = 1'b1;
      execution_vector.bit_mode        = (v.mode == ENABLED_64BIT_MODE) ? ENABLED_32BIT_MODE : ENABLED_64BIT_MODE;
      execution_vector.reciprocal_mode = ~v.recip;
      vl = 5'(v.vl ^ 7);
      @(negedge clk);
      if (v.n == 0) begin
        busy_e = 1'b0; rd_e = 1'b0; wr_e = 1'b0; done_e = (c == 1);
      end else begin
        busy_e = (c <= v.n + 2);
        rd_e   = (c <= v.n);
        wr_e   = (c >= 3 && c <= v.n + 2);
        done_e = (c == v.n + 3);
      end
      if (cut >= 0 && c > cut) begin
        busy_e = 1'b0; rd_e = 1'b0; wr_e = 1'b0; done_e = 1'b0;
      end
      mask_e = (c - 3 == v.n - 1) ? v.last_mask : 8'hFF;
      chk("busy", c, 80'(busy), 80'(busy_e));
      chk("done", c, 80'(done), 80'(done_e));
      if (rd_e) chk("read", c, 80'({rf.rf_read_enable, rf.rf_read_beat}), 80'({1'b1, 3'(c - 1)}));
      else      chk("read_enable", c, 80'(rf.rf_read_enable), 80'd0);
      if (wr_e) chk("write", c, 80'({rf.rf_write_enable, rf.rf_write_beat, rf.rf_write_data, rf.rf_write_mask}),
                    80'({1'b1, 3'(c - 3), v.exp_data, mask_e}));
      else      chk("write_enable", c, 80'(rf.rf_write_enable), 80'd0);
      if (c == cut && kind == 1) abort = 1'b1;
      if (c == cut && kind == 2) rst_n = 1'b0;
      if (c == restart_c) begin
        execution_vector.bit_mode        = ENABLED_64BIT_MODE;
        execution_vector.reciprocal_mode = 1'b0;
        vl    = 5'd8;
        start = 1'b1;
      end
      if (chain && c == v.n + 3) begin
        launch(nv);
        break;
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    execution_vector = '0;
    vl      = 5'd0;
    cur_src = IDLE_DATA;
    rf.rf_read_data = IDLE_DATA;

    vecs[0]  = '{ENABLED_64BIT_MODE, 1'b0, 3,  64'h4010_0000_0000_0000, 3, 64'h4000_0000_0000_0000, 8'hFF};
    vecs[1]  = '{ENABLED_32BIT_MODE, 1'b1, 3,  64'h4080_0000_4080_0000, 2, 64'h3F00_0000_3F00_0000, 8'h0F};
    vecs[2]  = '{ENABLED_32BIT_MODE, 1'b0, 20, 64'h4080_0000_4080_0000, 8, 64'h4000_0000_4000_0000, 8'hFF};
    vecs[3]  = '{ENABLED_64BIT_MODE, 1'b0, 0,  64'h4010_0000_0000_0000, 0, 64'h0,                   8'hFF};
    vecs[4]  = '{BIT_MODE_RESERVED,  1'b0, 4,  64'h4010_0000_0000_0000, 0, 64'h0,                   8'hFF};
    vecs[5]  = '{BIT_MODE_DISABLED,  1'b0, 4,  64'h4010_0000_0000_0000, 0, 64'h0,                   8'hFF};
    vecs[6]  = '{ENABLED_64BIT_MODE, 1'b1, 8,  64'h3FD0_0000_0000_0000, 8, 64'h4000_0000_0000_0000, 8'hFF};
    vecs[7]  = '{ENABLED_64BIT_MODE, 1'b0, 12, 64'h4022_0000_0000_0000, 8, 64'h4008_0000_0000_0000, 8'hFF};
    vecs[8]  = '{ENABLED_32BIT_MODE, 1'b0, 16, 64'h4180_0000_4180_0000, 8, 64'h4080_0000_4080_0000, 8'hFF};
    vecs[9]  = '{ENABLED_32BIT_MODE, 1'b1, 15, 64'h3E80_0000_3E80_0000, 8, 64'h4000_0000_4000_0000, 8'h0F};
    vecs[10] = '{ENABLED_64BIT_MODE, 1'b0, 1,  64'h4010_0000_0000_0000, 1, 64'h4000_0000_0000_0000, 8'hFF};
    vecs[11] = '{ENABLED_32BIT_MODE, 1'b0, 1,  64'h4080_0000_4080_0000, 1, 64'h4000_0000_4000_0000, 8'h0F};
    vecs[12] = '{ENABLED_64BIT_MODE, 1'b0, 2,  64'h4010_0000_0000_0000, 2, 64'h4000_0000_0000_0000, 8'hFF};

    repeat (2) @(negedge clk);
    chk("reset_read", 0, 80'({rf.rf_read_enable, rf.rf_read_beat}), 80'd0);
    chk("reset_write", 0, 80'({rf.rf_write_enable, rf.rf_write_beat, rf.rf_write_data, rf.rf_write_mask}), 80'd0);
    chk("reset_status", 0, 80'({busy, done}), 80'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      launch(vecs[i]);
      check_run(vecs[i], -1, 0, 0, 1'b0, vecs[i]);
    end

    // abort mid-run, then a clean run from beat 0
    launch(vecs[6]);
    check_run(vecs[6], 4, 1, 0, 1'b0, vecs[6]);
    launch(vecs[0]);
    check_run(vecs[0], -1, 0, 0, 1'b0, vecs[0]);

    // reset mid-run, then a clean run from beat 0
    launch(vecs[7]);
    check_run(vecs[7], 4, 2, 0, 1'b0, vecs[7]);
    launch(vecs[0]);
    check_run(vecs[0], -1, 0, 0, 1'b0, vecs[0]);

    // abort wins over a simultaneous start
    launch(vecs[0]);
    abort = 1'b1;
    check_run(vecs[0], 0, 0, 0, 1'b0, vecs[0]);

    // start while busy is ignored; start in the done cycle chains straight into the next run
    launch(vecs[12]);
    check_run(vecs[12], -1, 0, 2, 1'b1, vecs[1]);
    check_run(vecs[1], -1, 0, 0, 1'b0, vecs[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
